// File: rtl/parking_pkg.sv
// parking_pkg: shared constants, state types and helpers for the parking-lot
// status path.
//
// Contents:
//   MAX_SPACES            capacity of the lot
//   ASCII_*               characters used in the status record
//   tx_state_t            record-level FSM states (parking_status_tx)
//   bit_phase_t           bit-level phases (uart_tx_byte)
//   count_to_bcd()        6-bit count -> {tens, ones} BCD, compare/subtract only
//   status_letter()       flag pair -> status character, full has priority
package parking_pkg;

  localparam int unsigned MAX_SPACES = 20;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_F    = 8'h46;
  localparam logic [7:0] ASCII_A    = 8'h41;
  localparam logic [7:0] ASCII_E    = 8'h45;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_GAP
  } tx_state_t;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_START,
    PH_DATA,
    PH_PARITY,
    PH_STOP
  } bit_phase_t;

  // 63 is the largest input, so six conditional subtractions of ten are
  // enough to leave the ones digit in the remainder.
  function automatic logic [7:0] count_to_bcd(input logic [5:0] value);
    logic [5:0] rem;
    logic [3:0] tens;
    rem  = value;
    tens = 4'd0;
    for (int i = 0; i < 6; i++) begin
      if (rem >= 6'd10) begin
        rem  = rem - 6'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, rem[3:0]};
  endfunction

  function automatic logic [7:0] status_letter(input logic full,
                                               input logic available);
    logic [7:0] letter;
    if (full) begin
      letter = ASCII_F;
    end else if (available) begin
      letter = ASCII_A;
    end else begin
      letter = ASCII_E;
    end
    return letter;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: serialises one byte onto a UART line, LSB first.
//
// Build option: PARKING_TX_PARITY_EN
//   defined   -> start, 8 data, even parity, stop (11 bits)
//   undefined -> start, 8 data, stop (8N1, 10 bits)
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset
//   start  in   load data and begin a frame; accepted when idle or when done=1
//   data   in   byte to send, sampled with start
//   tx     out  serial line, idle high, registered
//   done   out  high during the final cycle of the stop bit
//
// Handshake: start is taken on any rising edge where the serialiser is idle
// or done is high, so a caller that answers done with start in the same cycle
// gets back-to-back frames with no idle time between them.
module uart_tx_byte
  import parking_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  bit_phase_t       phase;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             parity;
  logic             bit_end;

  assign bit_end = (baud_cnt == CNT_MAX);
  assign done    = (phase == PH_STOP) && bit_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase    <= PH_IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shreg    <= 8'd0;
      parity   <= 1'b0;
      tx       <= 1'b1;
    end else if (start && ((phase == PH_IDLE) || done)) begin
      phase    <= PH_START;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shreg    <= data;
      parity   <= ^data;
      tx       <= 1'b0;
    end else if (phase != PH_IDLE) begin
      if (bit_end) begin
        baud_cnt <= '0;
        case (phase)
          PH_START: begin
            phase <= PH_DATA;
            tx    <= shreg[0];
            shreg <= {1'b0, shreg[7:1]};
          end
          PH_DATA: begin
            if (bit_idx == 3'd7) begin
`ifdef PARKING_TX_PARITY_EN
              phase <= PH_PARITY;
              tx    <= parity;
`else
              phase <= PH_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end
          PH_PARITY: begin
            phase <= PH_STOP;
            tx    <= 1'b1;
          end
          default: begin
            phase <= PH_IDLE;
            tx    <= 1'b1;
          end
        endcase
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_status_tx.sv
// parking_status_tx: sends a 4-byte ASCII occupancy record over UART each
// time the parking controller strobes update: tens digit, ones digit,
// status letter (F/A/E), line feed.
//
// Build option: PARKING_TX_PARITY_EN (passed through to uart_tx_byte).
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   update     in   one-cycle strobe: snapshot inputs and report them
//   count[5:0] in   occupancy
//   full       in   lot-full flag
//   available  in   space-available flag
//   tx         out  UART line, idle high
//   busy       out  record in progress or one pending
//
// Strobes arriving while a record is in flight only refresh the snapshot and
// set pending, so any burst collapses into a single follow-up record carrying
// the newest values. The record being sent is frozen in LOAD and never changes.
module parking_status_tx
  import parking_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD        = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       update,
  input  logic [5:0] count,
  input  logic       full,
  input  logic       available,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;

  tx_state_t  state;
  tx_state_t  state_next;
  logic       pending;
  logic [5:0] snap_count;
  logic       snap_full;
  logic       snap_avail;
  logic [1:0] byte_idx;
  logic [7:0] rec_b1;
  logic [7:0] rec_b2;
  logic [7:0] rec_b3;
  logic [7:0] bcd;
  logic       byte_start;
  logic [7:0] byte_data;
  logic       byte_done;

  assign bcd  = count_to_bcd(snap_count);
  assign busy = (state != ST_IDLE) || pending;

  always_comb begin
    state_next = state;
    byte_start = 1'b0;
    byte_data  = 8'd0;
    case (state)
      ST_IDLE: begin
        if (update || pending) begin
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // Byte 0 goes straight to the serialiser; bytes 1..3 are latched.
        byte_start = 1'b1;
        byte_data  = ASCII_ZERO + {4'd0, bcd[7:4]};
        state_next = ST_SEND;
      end
      ST_SEND: begin
        if (byte_done) begin
          if (byte_idx == 2'd3) begin
            state_next = ST_GAP;
          end else begin
            byte_start = 1'b1;
            case (byte_idx)
              2'd0:    byte_data = rec_b1;
              2'd1:    byte_data = rec_b2;
              default: byte_data = rec_b3;
            endcase
          end
        end
      end
      ST_GAP: begin
        // A strobe landing here, or one already pending, chains straight
        // into the next record without passing through IDLE.
        if (update || pending) begin
          state_next = ST_LOAD;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pending    <= 1'b0;
      snap_count <= 6'd0;
      snap_full  <= 1'b0;
      snap_avail <= 1'b0;
      byte_idx   <= 2'd0;
      rec_b1     <= 8'd0;
      rec_b2     <= 8'd0;
      rec_b3     <= 8'd0;
    end else begin
      state <= state_next;
      if (update) begin
        snap_count <= count;
        snap_full  <= full;
        snap_avail <= available;
      end
      // The record started by entering LOAD consumes whatever snapshot is
      // current, so it also absorbs the pending request.
      if (state_next == ST_LOAD) begin
        pending <= 1'b0;
      end else if (update && (state != ST_IDLE)) begin
        pending <= 1'b1;
      end
      if (state == ST_LOAD) begin
        rec_b1   <= ASCII_ZERO + {4'd0, bcd[3:0]};
        rec_b2   <= status_letter(snap_full, snap_avail);
        rec_b3   <= ASCII_LF;
        byte_idx <= 2'd0;
      end else if ((state == ST_SEND) && byte_done && (byte_idx != 2'd3)) begin
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk  (clk),
    .rst  (rst),
    .start(byte_start),
    .data (byte_data),
    .tx   (tx),
    .done (byte_done)
  );

endmodule

// File: tb/tb_parking_status_tx.sv
// tb_parking_status_tx: directed bench for parking_status_tx.
// Runs the DUT at 8 clocks per bit; honours PARKING_TX_PARITY_EN.
module tb_parking_status_tx;
  import parking_pkg::*;

  localparam int unsigned CLK_HZ = 800;
  localparam int unsigned BAUD   = 100;
  localparam int CPB = 8;
`ifdef PARKING_TX_PARITY_EN
  localparam int BITS = 11;
`else
  localparam int BITS = 10;
`endif
  localparam int REC_CYC = 4 * BITS * CPB;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       update;
  logic [5:0] count;
  logic       full;
  logic       available;
  logic       tx;
  logic       busy;

  always #5 clk = ~clk;

  parking_status_tx #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD       (BAUD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .update   (update),
    .count    (count),
    .full     (full),
    .available(available),
    .tx       (tx),
    .busy     (busy)
  );

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic       par_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_record(input logic [7:0] tens, input logic [7:0] ones,
                               input logic [7:0] letter);
    exp_q.push_back(tens);
    exp_q.push_back(ones);
    exp_q.push_back(letter);
    exp_q.push_back(8'h0A);
  endtask

  task automatic drain_check(input string tag);
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rx_q.size() == 0) begin
        check_eq({tag, "_missing"}, 32'hDEAD, {24'd0, e});
      end else begin
        check_eq(tag, {24'd0, rx_q.pop_front()}, {24'd0, e});
      end
    end
    check_eq({tag, "_extra"}, rx_q.size(), 32'd0);
    rx_q.delete();
  endtask

  // UART receiver: samples each bit at its middle on the falling clock edge.
  initial begin : rx_monitor
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
`ifdef PARKING_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        par_q.push_back(tx);
`endif
        repeat (CPB) @(negedge clk);
        check_eq("stop_bit", {31'd0, tx}, 32'd1);
        rx_q.push_back(b);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a falling edge; update is seen by the following rising edge.
  task automatic send_update(input logic [5:0] c, input logic f, input logic a);
    count     = c;
    full      = f;
    available = a;
    update    = 1'b1;
    @(negedge clk);
    update    = 1'b0;
  endtask

  task automatic wait_busy_low(input string tag, input int budget, output int n);
    n = 0;
    while (busy === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      check_eq({tag, "_timeout"}, {31'd0, busy}, 32'd0);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int n;
    rst = 1'b1; update = 1'b0; count = 6'd0; full = 1'b0; available = 1'b0;
    step(3);
    rst = 1'b0;
    step(2);
    check_eq("reset_tx", {31'd0, tx}, 32'd1);
    check_eq("reset_busy", {31'd0, busy}, 32'd0);

    // Record "00A": latency and busy fall after the last stop bit.
    send_update(6'd0, 1'b0, 1'b1);
    check_eq("load_tx_high", {31'd0, tx}, 32'd1);
    check_eq("load_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check_eq("start_bit_latency", {31'd0, tx}, 32'd0);
    expect_record(8'h30, 8'h30, 8'h41);
    n = 1;
    while (busy === 1'b1 && n < REC_CYC + 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("busy_fall_cycle", n, REC_CYC + 2);
    drain_check("rec_00A");

    // Full has priority over available.
    send_update(6'(MAX_SPACES), 1'b1, 1'b1);
    expect_record(8'h32, 8'h30, 8'h46);
    wait_busy_low("rec_20F", REC_CYC + 50, n);
    drain_check("rec_20F");

    // Maximum count, no flags.
    send_update(6'd63, 1'b0, 1'b0);
    expect_record(8'h36, 8'h33, 8'h45);
    wait_busy_low("rec_63E", REC_CYC + 50, n);
    drain_check("rec_63E");

    // Three strobes during a record collapse to one follow-up with the last snapshot.
    send_update(6'd5, 1'b0, 1'b1);
    step(50);
    send_update(6'd30, 1'b1, 1'b0);
    step(20);
    send_update(6'd41, 1'b0, 1'b0);
    step(20);
    send_update(6'd7, 1'b0, 1'b1);
    check_eq("coalesce_busy", {31'd0, busy}, 32'd1);
    expect_record(8'h30, 8'h35, 8'h41);
    expect_record(8'h30, 8'h37, 8'h41);
    wait_busy_low("coalesce", 2 * REC_CYC + 50, n);
    step(2 * BITS * CPB);
    drain_check("coalesce");
    check_eq("coalesce_idle_busy", {31'd0, busy}, 32'd0);

    // Reset during byte 1 with a simultaneous update.
    send_update(6'd12, 1'b0, 1'b1);
    step(BITS * CPB + 3 * CPB);
    rst = 1'b1; update = 1'b1; count = 6'd40;
    @(negedge clk);
    check_eq("rst_tx", {31'd0, tx}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0; update = 1'b0;
    step(2 * BITS * CPB);
    rx_q.delete();
    par_q.delete();
    step(6 * BITS * CPB);
    check_eq("rst_no_output", rx_q.size(), 32'd0);
    check_eq("rst_idle_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_idle_tx", {31'd0, tx}, 32'd1);

    // Strobe in the GAP cycle chains the next record with no idle cycle.
    send_update(6'd9, 1'b0, 1'b1);
    @(negedge clk);
    step(REC_CYC);
    check_eq("gap_busy", {31'd0, busy}, 32'd1);
    check_eq("gap_tx", {31'd0, tx}, 32'd1);
    send_update(6'd33, 1'b1, 1'b0);
    check_eq("gap_load_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check_eq("gap_chain_start", {31'd0, tx}, 32'd0);
    expect_record(8'h30, 8'h39, 8'h41);
    expect_record(8'h33, 8'h33, 8'h46);
    wait_busy_low("gap_chain", REC_CYC + 50, n);
    drain_check("gap_chain");

    // Count 13, with parity bits checked in the parity build.
    par_q.delete();
    send_update(6'd13, 1'b0, 1'b1);
    expect_record(8'h31, 8'h33, 8'h41);
    wait_busy_low("rec_13A", REC_CYC + 50, n);
`ifdef PARKING_TX_PARITY_EN
    if (par_q.size() >= 2) begin
      check_eq("parity_0x31", {31'd0, par_q.pop_front()}, 32'd1);
      check_eq("parity_0x33", {31'd0, par_q.pop_front()}, 32'd0);
    end else begin
      check_eq("parity_count", par_q.size(), 32'd4);
    end
`endif
    drain_check("rec_13A");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
